// File: rtl/pong_match_ctrl_pkg.sv
// pong_match_ctrl_pkg: shared state/winner encodings and sizing helpers for the Pong match controller
package pong_match_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int BCD_W = 4;

    // Width of a counter that must hold the larger of two tick targets
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/pong_match_ctrl_bcd_countdown.sv
// bcd_countdown: M:SS BCD round clock that loads ROUND_MIN:00 and counts down to 0:00 without underflow
module bcd_countdown
    import pong_match_ctrl_pkg::*;
#(
    parameter int ROUND_MIN = 3
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_dec,
    output logic [BCD_W-1:0] o_min,
    output logic [BCD_W-1:0] o_sec_tens,
    output logic [BCD_W-1:0] o_sec_units,
    output logic             o_zero
);

    localparam logic [BCD_W-1:0] LOAD_MIN = BCD_W'(ROUND_MIN);

    logic [BCD_W-1:0] r_min;
    logic [BCD_W-1:0] r_sec_tens;
    logic [BCD_W-1:0] r_sec_units;
    logic             w_zero;

    assign w_zero      = (r_min == '0) && (r_sec_tens == '0) && (r_sec_units == '0);
    assign o_zero      = w_zero;
    assign o_min       = r_min;
    assign o_sec_tens  = r_sec_tens;
    assign o_sec_units = r_sec_units;

    // Load has priority; a decrement borrows units->tens->minutes and stops at 0:00
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_min       <= LOAD_MIN;
            r_sec_tens  <= '0;
            r_sec_units <= '0;
        end else if (i_load) begin
            r_min       <= LOAD_MIN;
            r_sec_tens  <= '0;
            r_sec_units <= '0;
        end else if (i_en && i_dec && !w_zero) begin
            if (r_sec_units != '0) begin
                r_sec_units <= r_sec_units - 1'b1;
            end else begin
                r_sec_units <= BCD_W'(9);
                if (r_sec_tens != '0) begin
                    r_sec_tens <= r_sec_tens - 1'b1;
                end else begin
                    r_sec_tens <= BCD_W'(5);
                    r_min      <= r_min - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: game-flow FSM owning scores, serve side, tick counter and the round clock
module pong_match_ctrl
    import pong_match_ctrl_pkg::*;
#(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 7,
    parameter int ROUND_MIN   = 3,
    parameter int SERVE_TICKS = 200,
    parameter int OVER_TICKS  = 300,
    parameter int AUTO_SERVE  = 0
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tick_100hz,
    input  logic               i_tick_1hz,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_mode,
    input  logic               i_miss1,
    input  logic               i_miss2,
    output logic [2:0]         o_state,
    output logic               o_stop,
    output logic               o_ball_reset,
    output logic               o_serve_dir,
    output logic [SCORE_W-1:0] o_score1,
    output logic [SCORE_W-1:0] o_score2,
    output logic [1:0]         o_winner,
    output logic [BCD_W-1:0]   o_min,
    output logic [BCD_W-1:0]   o_sec_tens,
    output logic [BCD_W-1:0]   o_sec_units
);

    localparam int                 CNT_W   = cnt_width(SERVE_TICKS, OVER_TICKS);
    localparam logic [CNT_W-1:0]   SERVE_N = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0]   OVER_N  = CNT_W'(OVER_TICKS);
    localparam logic [SCORE_W-1:0] WIN_N   = SCORE_W'(WIN_SCORE);

    state_t             r_state;
    logic               r_stop;
    logic               r_ball_reset;
    logic               r_serve_dir;
    logic               r_mode;
    logic [SCORE_W-1:0] r_score1;
    logic [SCORE_W-1:0] r_score2;
    logic [1:0]         r_winner;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_load;
    logic               w_dec;
    logic               w_zero;
    logic               w_miss;
    logic               w_timeout;
    logic               w_win_hit;
    logic [SCORE_W-1:0] w_score1_nx;
    logic [SCORE_W-1:0] w_score2_nx;

    // A lone miss credits the opponent (saturating); a double miss is a replay with no score change
    assign w_score1_nx = (i_miss2 && !i_miss1 && r_score1 != '1) ? r_score1 + 1'b1 : r_score1;
    assign w_score2_nx = (i_miss1 && !i_miss2 && r_score2 != '1) ? r_score2 + 1'b1 : r_score2;
    assign w_miss      = i_miss1 || i_miss2;
    assign w_win_hit   = r_mode && (w_score1_nx == WIN_N || w_score2_nx == WIN_N);
    assign w_timeout   = !r_mode && w_zero;
    assign w_load      = (r_state == ST_IDLE) && i_start;
    assign w_dec       = (r_state == ST_PLAY) && i_tick_1hz;

    bcd_countdown #(
        .ROUND_MIN (ROUND_MIN)
    ) u_clock (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load),
        .i_en        (!r_mode),
        .i_dec       (w_dec),
        .o_min       (o_min),
        .o_sec_tens  (o_sec_tens),
        .o_sec_units (o_sec_units),
        .o_zero      (w_zero)
    );

    // Match FSM: every output is a register updated alongside the state transition
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_stop       <= 1'b1;
            r_ball_reset <= 1'b0;
            r_serve_dir  <= 1'b0;
            r_mode       <= 1'b0;
            r_score1     <= '0;
            r_score2     <= '0;
            r_winner     <= WIN_NONE;
            r_cnt        <= '0;
        end else begin
            r_ball_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state      <= ST_SERVE;
                        r_score1     <= '0;
                        r_score2     <= '0;
                        r_winner     <= WIN_NONE;
                        r_mode       <= i_mode;
                        r_cnt        <= '0;
                        r_ball_reset <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (r_cnt == SERVE_N && (AUTO_SERVE != 0 || i_start)) begin
                        r_state <= ST_PLAY;
                        r_stop  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (i_tick_100hz && r_cnt != SERVE_N) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_miss) begin
                        r_score1 <= w_score1_nx;
                        r_score2 <= w_score2_nx;
                        r_stop   <= 1'b1;
                        r_cnt    <= '0;
                        if (i_miss1 != i_miss2) r_serve_dir <= i_miss2;
                        if (w_win_hit) begin
                            r_state  <= ST_OVER;
                            r_winner <= (w_score1_nx == WIN_N) ? WIN_P1 : WIN_P2;
                        end else begin
                            r_state      <= ST_SERVE;
                            r_ball_reset <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state  <= ST_OVER;
                        r_stop   <= 1'b1;
                        r_cnt    <= '0;
                        r_winner <= (r_score1 > r_score2) ? WIN_P1 :
                                    (r_score2 > r_score1) ? WIN_P2 : WIN_DRAW;
                    end else if (i_pause) begin
                        r_state <= ST_PAUSE;
                        r_stop  <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (i_pause) begin
                        r_state <= ST_PLAY;
                        r_stop  <= 1'b0;
                    end
                end
                ST_OVER: begin
                    if (r_cnt == OVER_N) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (i_tick_100hz) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_stop  <= 1'b1;
                end
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_stop       = r_stop;
    assign o_ball_reset = r_ball_reset;
    assign o_serve_dir  = r_serve_dir;
    assign o_score1     = r_score1;
    assign o_score2     = r_score2;
    assign o_winner     = r_winner;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: scoreboard bench; a seconds/points reference model predicts every cycle's outputs
module tb_pong_match_ctrl;
    import pong_match_ctrl_pkg::*;

    localparam int SERVE_T = 200;
    localparam int OVER_T  = 300;
    localparam int WIN     = 7;
    localparam int RMIN    = 3;
    localparam int SMAX    = 15;

    typedef struct packed {
        logic [2:0] st;
        logic       stop;
        logic       br;
        logic       dir;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] win;
        logic [3:0] mn;
        logic [3:0] tens;
        logic [3:0] units;
    } snap_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic tick100 = 1'b0, tick1 = 1'b0, start = 1'b0, pause = 1'b0;
    logic mode = 1'b0, miss1 = 1'b0, miss2 = 1'b0;
    logic [2:0] d_state;
    logic d_stop, d_br, d_dir;
    logic [3:0] d_s1, d_s2, d_min, d_tens, d_units;
    logic [1:0] d_win;

    snap_t q[$];
    int checks = 0, failures = 0, cycle = 0;

    state_t m_st;
    int m_s1, m_s2, m_secs, m_ticks, m_win;
    bit m_mode, m_dir, m_br;

    pong_match_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick_100hz(tick100), .i_tick_1hz(tick1),
        .i_start(start), .i_pause(pause), .i_mode(mode), .i_miss1(miss1), .i_miss2(miss2),
        .o_state(d_state), .o_stop(d_stop), .o_ball_reset(d_br), .o_serve_dir(d_dir),
        .o_score1(d_s1), .o_score2(d_s2), .o_winner(d_win),
        .o_min(d_min), .o_sec_tens(d_tens), .o_sec_units(d_units)
    );

    always #5 clk = ~clk;

    function automatic string fmt(snap_t s);
        return $sformatf("st=%0d stop=%0b br=%0b dir=%0b score=%0d:%0d win=%02b clock=%0d:%0d%0d",
                         s.st, s.stop, s.br, s.dir, s.s1, s.s2, s.win, s.mn, s.tens, s.units);
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.st    = m_st;
        s.stop  = (m_st != ST_PLAY);
        s.br    = m_br;
        s.dir   = m_dir;
        s.s1    = 4'(m_s1);
        s.s2    = 4'(m_s2);
        s.win   = 2'(m_win);
        s.mn    = 4'(m_secs / 60);
        s.tens  = 4'((m_secs % 60) / 10);
        s.units = 4'(m_secs % 10);
        return s;
    endfunction

    function automatic bit pc(input int per_mille);
        return $urandom_range(0, 999) < per_mille;
    endfunction

    task automatic model_reset();
        m_st = ST_IDLE; m_s1 = 0; m_s2 = 0; m_secs = RMIN * 60; m_ticks = 0;
        m_win = 0; m_mode = 0; m_dir = 0; m_br = 0;
    endtask

    // Game rules in plain arithmetic: the clock is a count of seconds, scores are integers
    task automatic model_step();
        bit timeout;
        m_br = 0;
        case (m_st)
            ST_IDLE: if (start) begin
                m_st = ST_SERVE; m_s1 = 0; m_s2 = 0; m_win = 0; m_secs = RMIN * 60;
                m_mode = mode; m_ticks = 0; m_br = 1;
            end
            ST_SERVE: begin
                if (m_ticks >= SERVE_T && start) begin m_st = ST_PLAY; m_ticks = 0; end
                else if (tick100 && m_ticks < SERVE_T) m_ticks++;
            end
            ST_PLAY: begin
                timeout = !m_mode && m_secs == 0;
                if (miss1 || miss2) begin
                    if (miss1 && !miss2) begin m_s2 = (m_s2 < SMAX) ? m_s2 + 1 : SMAX; m_dir = 0; end
                    if (miss2 && !miss1) begin m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX; m_dir = 1; end
                    if (m_mode && (m_s1 == WIN || m_s2 == WIN)) begin
                        m_st = ST_OVER; m_win = (m_s1 == WIN) ? 1 : 2;
                    end else begin
                        m_st = ST_SERVE; m_br = 1;
                    end
                    m_ticks = 0;
                end else if (timeout) begin
                    m_st = ST_OVER; m_ticks = 0;
                    m_win = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
                end else if (pause) begin
                    m_st = ST_PAUSE;
                end
                if (!m_mode && tick1 && m_secs > 0) m_secs--;
            end
            ST_PAUSE: if (pause) m_st = ST_PLAY;
            ST_OVER: begin
                if (m_ticks >= OVER_T) begin m_st = ST_IDLE; m_ticks = 0; end
                else if (tick100) m_ticks++;
            end
            default: m_st = ST_IDLE;
        endcase
    endtask

    task automatic cyc(input bit b_start, input bit b_pause, input bit b_m1, input bit b_m2,
                       input bit b_t100, input bit b_t1, input bit b_mode);
        @(negedge clk);
        rst_n = 1; start = b_start; pause = b_pause; miss1 = b_m1; miss2 = b_m2;
        tick100 = b_t100; tick1 = b_t1; mode = b_mode;
        model_step();
        q.push_back(model_snap());
        cycle++;
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n = 0; start = 0; pause = 0; miss1 = 0; miss2 = 0; tick100 = 0; tick1 = 0;
            model_reset();
            q.push_back(model_snap());
            cycle++;
        end
    endtask

    task automatic serve_to_play();
        repeat (SERVE_T) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic miss_serve(input bit m1, input bit m2);
        cyc(0, 0, m1, m2, 0, 0, 0);
        serve_to_play();
    endtask

    task automatic rnd(input bit md, input int ps, input int pp, input int pm, input int pt1);
        cyc(pc(ps), pc(pp), pc(pm), pc(pm), 1'($urandom_range(0, 1)), pc(pt1), md);
    endtask

    task automatic run_until(input state_t tgt, input int maxc, input bit md,
                             input int ps, input int pp, input int pm, input int pt1);
        int n = 0;
        while (m_st != tgt && n < maxc) begin rnd(md, ps, pp, pm, pt1); n++; end
        checks++;
        if (m_st != tgt) begin
            failures++;
            $display("FAIL reach_state cyc=%0d got model state %0d after %0d cycles, required %0d", cycle, m_st, n, tgt);
        end
    endtask

    task automatic monitor();
        snap_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                a = {d_state, d_stop, d_br, d_dir, d_s1, d_s2, d_win, d_min, d_tens, d_units};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got %s required %s", cycle, fmt(a), fmt(e));
                end
            end
        end
    endtask

    initial begin
        bit md;
        int n;
        fork monitor(); join_none
        model_reset();
        do_reset(3);
        // Manual serve: early start ignored, start after the full wait launches
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (150) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (50) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Pause freezes the clock at 1:30
        repeat (90) cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        // Reach 2:2, replay on a double miss, then 4:4 and a draw at 0:00
        miss_serve(0, 1); miss_serve(1, 0); miss_serve(0, 1); miss_serve(1, 0);
        miss_serve(1, 1);
        miss_serve(0, 1); miss_serve(1, 0); miss_serve(0, 1); miss_serve(1, 0);
        n = 0;
        while (m_secs > 0 && n < 400) begin cyc(0, 0, 0, 0, 0, 1, 0); n++; end
        cyc(0, 0, 0, 0, 0, 0, 0);
        run_until(ST_IDLE, 2000, 0, 0, 4, 20, 300);
        // Miss together with the final second: the point counts before the timeout
        cyc(1, 0, 0, 0, 0, 0, 0);
        serve_to_play();
        repeat (179) cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        serve_to_play();
        cyc(0, 0, 0, 0, 0, 0, 0);
        run_until(ST_IDLE, 2000, 0, 0, 4, 20, 300);
        // Score saturation in timed mode
        cyc(1, 0, 0, 0, 0, 0, 0);
        serve_to_play();
        repeat (17) miss_serve(0, 1);
        do_reset(1);
        // Reset mid-play at 3:2
        cyc(1, 0, 0, 0, 0, 0, 0);
        serve_to_play();
        miss_serve(0, 1); miss_serve(0, 1); miss_serve(0, 1); miss_serve(1, 0); miss_serve(1, 0);
        do_reset(2);
        // First-to-7: 6:0 then the winning point, hold OVER, back to IDLE
        cyc(1, 0, 0, 0, 0, 0, 1);
        serve_to_play();
        repeat (6) miss_serve(0, 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        repeat (OVER_T) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Randomised full games in both modes
        for (int g = 0; g < 4; g++) begin
            md = 1'($urandom_range(0, 1));
            cyc(1, 0, 0, 0, 0, 0, md);
            run_until(ST_OVER, 30000, md, 40, 4, md ? 20 : 5, 300);
            run_until(ST_IDLE, 2000, md, 0, 4, 20, 300);
        end
        // Random game aborted by reset
        md = 1'($urandom_range(0, 1));
        cyc(1, 0, 0, 0, 0, 0, md);
        repeat (1200) rnd(md, 40, 4, 20, 300);
        do_reset(1);
        repeat (3) cyc(0, 0, 0, 0, 1, 1, 0);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending entries, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
